dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the shared `data_memory` block: the CPU load/store unit (port 0) and the debug/loader (port 1).
- Accepts one request at a time, using round-robin between the ports.
- Rejects illegal addresses without touching memory.
- Drives the memory's three-cycle access protocol, holding address, size and data stable for the whole access.
- Routes the result back to the requesting port.

Sits between the pipeline MEM stage / loader and `data_memory`.

## Interface
Parameters:
- `MEM_BASE`, default 32'h0000_8000: first valid data-memory byte address.
- `MEM_LAST`, default 32'h0001_7fff: last valid data-memory byte address.
- `IO_LOW`, default 32'h0002_fff0: first IO byte address (write-only).
- `IO_HIGH`, default 32'h0002_ffff: last IO byte address.

Ports (arrays indexed by port number p ∈ {0,1}):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `req_valid` in [1:0]: request present. Must stay asserted, with all request fields stable, until accepted.
- `req_ready` out [1:0]: request accepted this cycle (`req_valid[p] && req_ready[p]`).
- `req_write` in [1:0]: 1 = store, 0 = load.
- `req_signed` in [1:0]: sign-extend the load result.
- `req_xfer` in [1:0][1:0]: transfer size, XFER_BYTE/XFER_HALF/XFER_WORD (from `constants.svh`).
- `req_addr` in [1:0][31:0]: byte address.
- `req_wdata` in [1:0][31:0]: store data, LSB-aligned.
- `rsp_valid` out [1:0]: one-cycle response pulse.
- `rsp_err` out 1: response is an error (qualified by any `rsp_valid`).
- `rsp_data` out 32: load data. 0 for stores and errors.
- `mem_read_en`, `mem_write_en` out 1: one-cycle enable pulses to memory.
- `mem_is_signed` out 1, `mem_xfer_size` out 2, `mem_address` out 32, `mem_write_data` out 32: held memory controls.
- `mem_read_data` in 32: memory result, valid in the RESP cycle.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT1, WAIT2, RESP, ERR.
- **Arbitration (IDLE only):**
  - Winner = the single valid port; if both ports are valid, the port ≠ `last_grant`.
  - `req_ready[winner]=1` combinationally; all other `req_ready` are 0 in every other state.
  - `last_grant` updates on accept and resets to 1, so port 0 wins the first tie.
- **Legality check at accept**, with size n = 1/2/4:
  - Error if misaligned: a half at an odd address, or a word with `addr[1:0]≠0`.
  - Error if reserved xfer encoding 2'b11.
  - Legal if the whole access lies in [MEM_BASE, MEM_LAST], i.e. `addr ≥ MEM_BASE && addr+n-1 ≤ MEM_LAST`, computed in 33 bits with no wrap.
  - Legal if it is a store lying entirely in [IO_LOW, IO_HIGH].
  - Everything else is an error, including IO loads.
- **Transitions:**
  - IDLE→ISSUE on a legal accept; IDLE→ERR on an illegal accept.
  - ISSUE→WAIT1→WAIT2→RESP→IDLE; ERR→IDLE.
- **Registers captured on a legal accept:** `mem_address`, `mem_write_data`, `mem_xfer_size`, `mem_is_signed`, plus the owner port.
  - They hold unchanged until the next legal accept.
- **ISSUE:** exactly one of `mem_read_en`/`mem_write_en` = 1; both are 0 in all other states.
- **RESP:**
  - `rsp_valid[owner]=1`, `rsp_err=0`.
  - `rsp_data = mem_read_data` for loads, 0 for stores.
- **ERR:** `rsp_valid[owner]=1`, `rsp_err=1`, `rsp_data=0`. No memory enable.
- `rsp_err` and `rsp_data` are 0 whenever no `rsp_valid` is set.

## Timing
- Let A = the accept cycle.
- **Legal access:**
  - Enable pulses in A+1 (ISSUE).
  - Memory controls are stable A+1..A+3.
  - Memory acts on the clock edge ending A+3.
  - `rsp_valid` is high in A+4.
  - The next accept is possible no earlier than A+5. Throughput: 1 access per 5 cycles.
- **Illegal access:** `rsp_valid` in A+1; next accept at A+2.
- **Valid vs ready:** a requester may not gate `req_valid` on `req_ready`. `req_ready` depends only on state, `req_valid` and `last_grant`.
- **Simultaneous events:** a request arriving during a busy sequence waits with `req_ready=0` and no starvation (round-robin). A port's own new request is accepted in IDLE after its response.
- **Reset behaviour:**
  - State → IDLE, `last_grant` → 1.
  - `req_ready`, `rsp_valid`, `rsp_err`, `rsp_data`, `mem_read_en`, `mem_write_en` → 0.
  - `mem_address`, `mem_write_data`, `mem_xfer_size`, `mem_is_signed` are not reset; they hold their value. This way an access already pipelined inside memory completes at its intended address.
  - The response for an access in flight at reset is dropped.
- **Outputs registered vs combinational:**
  - Memory-side outputs are registered.
  - `rsp_valid` and `rsp_err` are decoded from state.
  - `rsp_data` passes `mem_read_data` through in RESP.

## Test plan
- **Port-0 word round trip:** store word 0xdeadbeef to 0x8004, then load word 0x8004 (signed). Expect:
  - `mem_write_en` exactly one cycle, in A+1.
  - `rsp_valid[0]` in A+4.
  - The load returns 0xdeadbeef with `rsp_err=0`.
- **Sign extension:** store byte 0x80 to 0x8010. Then:
  - Signed byte load → 0xffffff80.
  - Unsigned byte load → 0x00000080.
  - Half store 0x8001 at 0x8012, signed half load → 0xffff8001.
- **Contention:** both ports valid on the same cycle after reset. Expect:
  - Port 0 served first, then port 1.
  - Hold both valid: grants alternate 0,1,0,1.
  - Every response pulse goes only to its owner.
- **Errors:** each of the following gives `rsp_err=1` at A+1, `rsp_data=0`, and no memory enable:
  - load word 0x8002 (misaligned);
  - load half 0x7fff;
  - load word 0x17ffd;
  - load byte 0x2fff0 (IO read).
  - Store byte 0x41 to 0x2fff0 is legal: `mem_write_en` in A+1, response at A+4.
- **Hold checks:** for every legal access, `mem_address`, `mem_write_data` and `mem_xfer_size` are constant A+1..A+3. Changing `req_addr` after accept does not alter them.
- **Reset mid-op:** assert reset in A+2 of a store to 0x8020. Expect:
  - All response and enable outputs 0 next cycle.
  - No `rsp_valid`.
  - `mem_address` still 0x8020.
  - After release, port 0 wins a tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer for the shared data_memory.
// Ports: clk/reset (sync, active-high); per-port request req_* with req_ready accept strobe;
// per-port rsp_valid pulse with shared rsp_err/rsp_data; held mem_* controls with one-cycle
// mem_read_en/mem_write_en pulses; mem_read_data returned by memory in the RESP cycle.
module dmem_arbiter #(
  parameter logic [31:0] MEM_BASE = 32'h0000_8000,
  parameter logic [31:0] MEM_LAST = 32'h0001_7fff,
  parameter logic [31:0] IO_LOW   = 32'h0002_fff0,
  parameter logic [31:0] IO_HIGH  = 32'h0002_ffff
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0]       req_signed,
  input  logic [1:0][1:0]  req_xfer,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  output logic [1:0]       rsp_valid,
  output logic             rsp_err,
  output logic [31:0]      rsp_data,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             mem_is_signed,
  output logic [1:0]       mem_xfer_size,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);
  localparam logic [1:0] XFER_BYTE = 2'b00;
  localparam logic [1:0] XFER_HALF = 2'b01;
  localparam logic [1:0] XFER_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT1, WAIT2, RESP, ERR} state_t;
  state_t      r_state;
  logic        r_last_grant;
  logic        r_owner;
  logic        r_write;
  logic        w_win;
  logic        w_accept;
  logic [1:0]  w_xfer;
  logic [31:0] w_addr;
  logic [32:0] w_n;
  logic [32:0] w_last;
  logic        w_bad_form;
  logic        w_in_mem;
  logic        w_in_io;
  logic        w_legal;
  // The end address is formed in 33 bits so an access near 4 GiB cannot wrap into range.
  always_comb begin
    w_win      = &req_valid ? ~r_last_grant : req_valid[1];
    w_accept   = r_state == IDLE && |req_valid && !reset;
    req_ready  = w_accept ? 2'b01 << w_win : 2'b00;
    w_addr     = req_addr[w_win];
    w_xfer     = req_xfer[w_win];
    w_n        = w_xfer == XFER_BYTE ? 33'd1 : w_xfer == XFER_HALF ? 33'd2 : 33'd4;
    w_last     = {1'b0, w_addr} + w_n - 33'd1;
    w_bad_form = (w_xfer == XFER_HALF && w_addr[0]) || (w_xfer == XFER_WORD && w_addr[1:0] != 2'b00) || w_xfer == 2'b11;
    w_in_mem   = w_addr >= MEM_BASE && w_last <= {1'b0, MEM_LAST};
    w_in_io    = req_write[w_win] && w_addr >= IO_LOW && w_last <= {1'b0, IO_HIGH};
    w_legal    = !w_bad_form && (w_in_mem || w_in_io);
    rsp_valid  = (r_state == RESP || r_state == ERR) ? 2'b01 << r_owner : 2'b00;
    rsp_err    = r_state == ERR;
    rsp_data   = (r_state == RESP && !r_write) ? mem_read_data : 32'd0;
  end
  // Memory controls are deliberately outside the reset branch so an access already
  // inside memory completes at its intended address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_last_grant <= w_win;
          r_owner      <= w_win;
          r_write      <= req_write[w_win];
          r_state      <= w_legal ? ISSUE : ERR;
          if (w_legal) begin
            mem_address    <= w_addr;
            mem_write_data <= req_wdata[w_win];
            mem_xfer_size  <= w_xfer;
            mem_is_signed  <= req_signed[w_win];
            mem_write_en   <= req_write[w_win];
            mem_read_en    <= !req_write[w_win];
          end
        end
        ISSUE:   r_state <= WAIT1;
        WAIT1:   r_state <= WAIT2;
        WAIT2:   r_state <= RESP;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
